// File: rtl/matrix_column_scanner.sv
// -----------------------------------------------------------------------------
// matrix_column_scanner
//
// Time-multiplexed driver for a 5-column x 7-row LED matrix. Each column gets a
// slot of SLOT_CYCLES clocks. The first BLANK_CYCLES of every slot drive all
// columns off (anti-ghosting) and the rest drive one column low together with
// that column's row pattern. All five column patterns are captured into shadow
// registers at the start of every frame, so a frame is always self-consistent.
// After every FRAMES_PER_MODE completed frames, display_selector toggles so
// that the upstream stage alternates between its two images.
//
// Ports:
//   clock              sole clock, rising edge
//   reset_n            asynchronous active-low reset
//   enable             scan enable; low stops the scan and blanks the matrix
//   column_4..column_0 row patterns, 1 = LED lit
//   column_select      active-low one-hot-zero column drive (bit i = column_i)
//   row_data           active-high row drive
//   display_selector   1 = state image, 0 = water column
//   frame_done         one-cycle pulse after each completed frame
//
// Handshake: none; enable is a level, frame_done a single-cycle strobe.
// Every output is a flop loaded from the next-state values, so outputs on the
// cycle after an edge always describe the slot position entered on that edge.
// -----------------------------------------------------------------------------
module matrix_column_scanner #(
  parameter int SLOT_CYCLES     = 1000,
  parameter int BLANK_CYCLES    = 50,
  parameter int FRAMES_PER_MODE = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] column_4,
  input  logic [6:0] column_3,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  output logic [4:0] column_select,
  output logic [6:0] row_data,
  output logic       display_selector,
  output logic       frame_done
);

  localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int FCNT_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [2:0]        IDX_LAST  = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              ds_nxt;
  logic              latch;      // this edge starts slot 0: capture all columns
  logic              frame_wrap; // this edge completes a frame (idx 4 -> 0)
  logic              blank_nxt;
  logic [6:0]        shadow_0, shadow_1, shadow_2, shadow_3, shadow_4;
  logic [6:0]        row_src;
  logic [4:0]        select_nxt;
  logic [6:0]        row_nxt;

  // Sequencing: start, slot advance, frame wrap and stop.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    latch      = 1'b0;
    frame_wrap = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (state == ST_IDLE) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      latch     = 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      if (idx == IDX_LAST) begin
        idx_nxt    = '0;
        latch      = 1'b1;
        frame_wrap = 1'b1;
      end else begin
        idx_nxt = idx + 3'd1;
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Mode alternation: only a frame wrap can move fcnt or display_selector.
  always_comb begin
    fcnt_nxt = fcnt;
    ds_nxt   = display_selector;
    if (frame_wrap) begin
      if (fcnt == FCNT_LAST) begin
        fcnt_nxt = '0;
        ds_nxt   = ~display_selector;
      end else begin
        fcnt_nxt = fcnt + FCNT_W'(1);
      end
    end
  end

  // Blanking window at the head of each slot; absent entirely when zero.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYCLES);
      assign blank_nxt = (cnt_nxt < BLANK_L);
    end else begin : g_no_blank
      assign blank_nxt = 1'b0;
    end
  endgenerate

  // Row pattern for the column entered on this edge. On a latching edge the
  // shadows are being loaded, so slot 0 must take column_0 directly.
  always_comb begin
    row_src = '0;
    case (idx_nxt)
      3'd0:    row_src = latch ? column_0 : shadow_0;
      3'd1:    row_src = shadow_1;
      3'd2:    row_src = shadow_2;
      3'd3:    row_src = shadow_3;
      3'd4:    row_src = shadow_4;
      default: row_src = '0;
    endcase
  end

  always_comb begin
    select_nxt = 5'b11111;
    row_nxt    = '0;
    if (enable && !blank_nxt) begin
      select_nxt = ~(5'b00001 << idx_nxt);
      row_nxt    = row_src;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      idx              <= '0;
      fcnt             <= '0;
      shadow_0         <= '0;
      shadow_1         <= '0;
      shadow_2         <= '0;
      shadow_3         <= '0;
      shadow_4         <= '0;
      column_select    <= 5'b11111;
      row_data         <= '0;
      display_selector <= 1'b1;
      frame_done       <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      idx              <= idx_nxt;
      fcnt             <= fcnt_nxt;
      column_select    <= select_nxt;
      row_data         <= row_nxt;
      display_selector <= ds_nxt;
      frame_done       <= frame_wrap;
      if (latch) begin
        shadow_0 <= column_0;
        shadow_1 <= column_1;
        shadow_2 <= column_2;
        shadow_3 <= column_3;
        shadow_4 <= column_4;
      end
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
module tb_matrix_column_scanner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       enable_nb;
  logic [6:0] column_4, column_3, column_2, column_1, column_0;
  logic [4:0] cs, cs_nb;
  logic [6:0] rd, rd_nb;
  logic       ds, ds_nb;
  logic       fd, fd_nb;

  int checks_total  = 0;
  int checks_passed = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  matrix_column_scanner #(
    .SLOT_CYCLES(4), .BLANK_CYCLES(1), .FRAMES_PER_MODE(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .column_4(column_4), .column_3(column_3), .column_2(column_2),
    .column_1(column_1), .column_0(column_0),
    .column_select(cs), .row_data(rd),
    .display_selector(ds), .frame_done(fd)
  );

  matrix_column_scanner #(
    .SLOT_CYCLES(4), .BLANK_CYCLES(0), .FRAMES_PER_MODE(2)
  ) dut_nb (
    .clock(clock), .reset_n(reset_n), .enable(enable_nb),
    .column_4(column_4), .column_3(column_3), .column_2(column_2),
    .column_1(column_1), .column_0(column_0),
    .column_select(cs_nb), .row_data(rd_nb),
    .display_selector(ds_nb), .frame_done(fd_nb)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [6:0] c0;
    logic [6:0] c4;
    logic [4:0] cs;
    logic [6:0] rd;
    logic       fd;
    logic       ds;
  } vec_t;

  vec_t       vecs[42];
  logic [4:0] sel_tab[5];
  logic [6:0] row_f0[5];
  logic [6:0] row_f1[5];
  logic [6:0] row_nb[5];

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      checks_passed++;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_cs, input logic [6:0] e_rd,
                         input logic e_fd, input logic e_ds);
    chk({tag, ".column_select"}, 32'(cs), 32'(e_cs));
    chk({tag, ".row_data"}, 32'(rd), 32'(e_rd));
    chk({tag, ".frame_done"}, 32'(fd), 32'(e_fd));
    chk({tag, ".display_selector"}, 32'(ds), 32'(e_ds));
  endtask

  initial begin
    sel_tab = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    row_f0  = '{7'h08, 7'h14, 7'h22, 7'h41, 7'h7F};
    row_f1  = '{7'h55, 7'h14, 7'h22, 7'h41, 7'h2A};
    row_nb  = '{7'h11, 7'h14, 7'h22, 7'h41, 7'h2A};

    // Edge e after enable: slot (e%20)/4, cycle e%4; cycle 0 of each slot blank.
    // column_0/column_4 change from edge 9 (inside slot 2); visible next frame.
    for (int e = 0; e < 42; e++) begin
      int slot, cyc, fr;
      slot = (e % 20) / 4;
      cyc  = e % 4;
      fr   = e / 20;
      vecs[e].en = 1'b1;
      vecs[e].c0 = (e >= 9) ? 7'h55 : 7'h08;
      vecs[e].c4 = (e >= 9) ? 7'h2A : 7'h7F;
      if (cyc == 0) begin
        vecs[e].cs = 5'b11111;
        vecs[e].rd = 7'h00;
      end else begin
        vecs[e].cs = sel_tab[slot];
        vecs[e].rd = (fr == 0) ? row_f0[slot] : row_f1[slot];
      end
      vecs[e].fd = (e == 20 || e == 40);
      vecs[e].ds = (e >= 40) ? 1'b0 : 1'b1;
    end

    // ---- reset state ----
    reset_n   = 1'b0;
    enable    = 1'b0;
    enable_nb = 1'b0;
    column_4 = 7'h7F; column_3 = 7'h41; column_2 = 7'h22;
    column_1 = 7'h14; column_0 = 7'h08;
    step();
    step();
    chk_out("reset", 5'b11111, 7'h00, 1'b0, 1'b1);
    reset_n = 1'b1;
    step();
    chk_out("idle_disabled", 5'b11111, 7'h00, 1'b0, 1'b1);

    // ---- basic scan, latch isolation, first mode flip ----
    for (int i = 0; i < 42; i++) begin
      enable   = vecs[i].en;
      column_0 = vecs[i].c0;
      column_4 = vecs[i].c4;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].cs, vecs[i].rd, vecs[i].fd, vecs[i].ds);
    end

    // ---- continuous scan: pulses every 20 cycles, flip back after 4th ----
    for (int e = 42; e <= 80; e++) begin
      step();
      chk($sformatf("mode_e%0d.frame_done", e), 32'(fd), 32'(e == 60 || e == 80));
      chk($sformatf("mode_e%0d.display_selector", e), 32'(ds), 32'((e >= 80) ? 1 : 0));
    end

    // ---- mid-slot-4 disable ----
    for (int e = 81; e <= 97; e++) step();
    chk_out("slot4_before_drop", 5'b01111, 7'h2A, 1'b0, 1'b1);
    enable   = 1'b0;
    column_0 = 7'h11;
    step();
    chk_out("drop_edge", 5'b11111, 7'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("disabled%0d", k), 5'b11111, 7'h00, 1'b0, 1'b1);
    end

    // ---- re-enable: fresh latch, no start pulse, fcnt was held ----
    enable = 1'b1;
    step();
    chk_out("restart_r0", 5'b11111, 7'h00, 1'b0, 1'b1);
    step();
    chk_out("restart_r1", 5'b11110, 7'h11, 1'b0, 1'b1);
    for (int r = 2; r <= 40; r++) begin
      step();
      chk($sformatf("restart_r%0d.frame_done", r), 32'(fd), 32'(r == 20 || r == 40));
      chk($sformatf("restart_r%0d.display_selector", r), 32'(ds), 32'((r >= 40) ? 0 : 1));
    end

    // ---- asynchronous reset between edges while display_selector=0 ----
    #3;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 5'b11111, 7'h00, 1'b0, 1'b1);
    step();
    chk_out("reset_held", 5'b11111, 7'h00, 1'b0, 1'b1);
    reset_n = 1'b1;
    step();
    chk_out("post_reset_r0", 5'b11111, 7'h00, 1'b0, 1'b1);
    step();
    chk_out("post_reset_r1", 5'b11110, 7'h11, 1'b0, 1'b1);

    // ---- single-cycle enable pulse ----
    enable = 1'b0;
    step();
    chk_out("pulse_pre", 5'b11111, 7'h00, 1'b0, 1'b1);
    enable = 1'b1;
    step();
    chk_out("pulse_start", 5'b11111, 7'h00, 1'b0, 1'b1);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("pulse_stop%0d", k), 5'b11111, 7'h00, 1'b0, 1'b1);
    end

    // ---- no blanking instance ----
    enable_nb = 1'b1;
    for (int e = 0; e < 45; e++) begin
      int slot;
      slot = (e % 20) / 4;
      step();
      checks_total++;
      if (cs_nb === 5'b11111)
        $display("FAIL nb_e%0d.never_blank: got %0h expected not 1f", e, cs_nb);
      else
        checks_passed++;
      chk($sformatf("nb_e%0d.column_select", e), 32'(cs_nb), 32'(sel_tab[slot]));
      chk($sformatf("nb_e%0d.row_data", e), 32'(rd_nb), 32'(row_nb[slot]));
      chk($sformatf("nb_e%0d.frame_done", e), 32'(fd_nb), 32'(e == 20 || e == 40));
      chk($sformatf("nb_e%0d.display_selector", e), 32'(ds_nb), 32'((e >= 40) ? 0 : 1));
    end
    enable_nb = 1'b0;
    step();
    chk("nb_disable.column_select", 32'(cs_nb), 32'(5'b11111));

    // ---- report ----
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
